// File: rtl/rx_frame_buffer_if.sv
// MAC receive beats, released byte stream and status of the receive frame buffer.
`timescale 1ns/1ps
interface rx_frame_buffer_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              rx_mac_valid;
    logic [7:0]        rx_mac_data;
    logic              rx_mac_last;
    logic              rx_mac_error;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_ready;
    logic [15:0]       frames_ok;
    logic [15:0]       frames_dropped;
    logic              overflow;
    logic [ADDR_W:0]   buf_level;

    modport slave (
        input  rx_mac_valid, rx_mac_data, rx_mac_last, rx_mac_error, out_ready,
        output out_valid, out_data, out_last, frames_ok, frames_dropped, overflow, buf_level
    );

    modport master (
        output rx_mac_valid, rx_mac_data, rx_mac_last, rx_mac_error, out_ready,
        input  out_valid, out_data, out_last, frames_ok, frames_dropped, overflow, buf_level
    );
endinterface

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive buffer: frames are written into a circular byte RAM and
// released downstream only once complete and error-free; bad frames are rolled back.
`timescale 1ns/1ps
module rx_frame_buffer #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MIN_LEN = 14
) (
    input  logic               rx_mac_clk,
    input  logic               rstn,
    rx_frame_buffer_if.slave   bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_RESYNC, S_IDLE, S_RECV, S_DROP} state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic [PTR_W-1:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [15:0]        r_len, w_len_beat;
    logic               r_bad, w_bad_beat;
    logic               w_full;
    logic               w_wr_en, w_commit, w_rollback, w_ovf;
    logic [15:0]        r_frames_ok, r_frames_dropped;
    logic               r_overflow;
    logic [PTR_W-1:0]   r_buf_level;
    logic [8:0]         r_mem [DEPTH];
    logic [8:0]         r_ram_q;
    logic               r_s1_valid;
    logic               r_out_valid, r_out_last;
    logic [7:0]         r_out_data;
    logic               w_pop, w_s1_move, w_rd_issue;

    assign w_full     = (r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH);
    assign w_len_beat = (r_state == S_IDLE) ? 16'd1 :
                        ((r_len == 16'hFFFF) ? r_len : r_len + 16'd1);
    assign w_bad_beat = r_bad | bus.rx_mac_error;

    always_ff @(posedge rx_mac_clk or negedge rstn) begin
        if (!rstn) r_state <= S_RESYNC;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESYNC: if (bus.rx_mac_valid && bus.rx_mac_last) w_state_nxt = S_IDLE;
            S_IDLE, S_RECV: begin
                if (bus.rx_mac_valid) begin
                    if (bus.rx_mac_last)  w_state_nxt = S_IDLE;
                    else if (w_full)      w_state_nxt = S_DROP;
                    else                  w_state_nxt = S_RECV;
                end
            end
            S_DROP:   if (bus.rx_mac_valid && bus.rx_mac_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_RESYNC;
        endcase
    end

    // Per-beat write actions; a last beat seen while full is treated as a drop.
    always_comb begin
        w_wr_en    = 1'b0;
        w_commit   = 1'b0;
        w_rollback = 1'b0;
        w_ovf      = 1'b0;
        case (r_state)
            S_IDLE, S_RECV: begin
                if (bus.rx_mac_valid) begin
                    if (w_full) begin
                        w_ovf      = 1'b1;
                        w_rollback = bus.rx_mac_last;
                    end else if (bus.rx_mac_last) begin
                        if (!w_bad_beat && (w_len_beat >= 16'(MIN_LEN))) begin
                            w_wr_en  = 1'b1;
                            w_commit = 1'b1;
                        end else begin
                            w_rollback = 1'b1;
                        end
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end
            end
            S_DROP:  w_rollback = bus.rx_mac_valid && bus.rx_mac_last;
            default: ;
        endcase
    end

    assign w_wr_ptr_nxt = w_rollback ? r_cmt_ptr :
                          (w_wr_en ? r_wr_ptr + PTR_W'(1) : r_wr_ptr);
    assign w_rd_ptr_nxt = w_rd_issue ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_ff @(posedge rx_mac_clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr         <= '0;
            r_cmt_ptr        <= '0;
            r_rd_ptr         <= '0;
            r_len            <= '0;
            r_bad            <= 1'b0;
            r_frames_ok      <= '0;
            r_frames_dropped <= '0;
            r_overflow       <= 1'b0;
            r_buf_level      <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_overflow  <= w_ovf;
            r_buf_level <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            if (w_commit) r_cmt_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_state_nxt != S_RECV) begin
                r_len <= '0;
                r_bad <= 1'b0;
            end else if (w_wr_en) begin
                r_len <= w_len_beat;
                r_bad <= w_bad_beat;
            end
            if (w_commit && (r_frames_ok != 16'hFFFF))
                r_frames_ok <= r_frames_ok + 16'd1;
            if (w_rollback && (r_frames_dropped != 16'hFFFF))
                r_frames_dropped <= r_frames_dropped + 16'd1;
        end
    end

    // Two-slot read pipeline: RAM read register feeding a stallable output register.
    assign w_pop      = r_out_valid && bus.out_ready;
    assign w_s1_move  = r_s1_valid && (!r_out_valid || w_pop);
    assign w_rd_issue = (r_rd_ptr != r_cmt_ptr) && (!r_s1_valid || w_s1_move);

    always_ff @(posedge rx_mac_clk) begin
        if (w_wr_en)    r_mem[r_wr_ptr[ADDR_W-1:0]] <= {w_commit, bus.rx_mac_data};
        if (w_rd_issue) r_ram_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge rx_mac_clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_rd_issue)     r_s1_valid <= 1'b1;
            else if (w_s1_move) r_s1_valid <= 1'b0;
            if (w_s1_move) begin
                r_out_valid <= 1'b1;
                r_out_last  <= r_ram_q[8];
                r_out_data  <= r_ram_q[7:0];
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_data       = r_out_data;
    assign bus.out_last       = r_out_last;
    assign bus.frames_ok      = r_frames_ok;
    assign bus.frames_dropped = r_frames_dropped;
    assign bus.overflow       = r_overflow;
    assign bus.buf_level      = r_buf_level;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: resync, latency, drops, overflow and back-to-back frames.
`timescale 1ns/1ps
module tb_rx_frame_buffer;
    localparam int unsigned ADDR_W = 11;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rx_frame_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    rx_frame_buffer #(.ADDR_W(ADDR_W), .MIN_LEN(14)) dut (
        .rx_mac_clk (clk),
        .rstn       (rstn),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    int rdy_mode = 1;
    int stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = '0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    // out_ready: 0 = held low, 1 = held high, 2 = random
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Capture accepted bytes and watch that stalled outputs hold still.
    always @(negedge clk) begin
        if (prev_stall && (!bus.out_valid || ({bus.out_last, bus.out_data} !== prev_beat)))
            stall_viol++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_beat  = {bus.out_last, bus.out_data};
        if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic beat(input logic [7:0] d, input logic l, input logic e);
        bus.rx_mac_valid = 1'b1;
        bus.rx_mac_data  = d;
        bus.rx_mac_last  = l;
        bus.rx_mac_error = e;
        @(posedge clk); #1;
    endtask

    task automatic go_idle();
        bus.rx_mac_valid = 1'b0;
        bus.rx_mac_last  = 1'b0;
        bus.rx_mac_error = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        go_idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int f, input int len, input bit err_last, input bit good);
        for (int i = 0; i < len; i++) begin
            if (good) exp_q.push_back({1'(i == len - 1), 8'(f * 7 + i)});
            beat(8'(f * 7 + i), 1'(i == len - 1), 1'(err_last && (i == len - 1)));
        end
        go_idle();
    endtask

    task automatic wait_drain(input int limit, output bit timed_out);
        int n = 0;
        go_idle();
        while ((got_q.size() < exp_q.size() || bus.out_valid || bus.buf_level != '0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        timed_out = (n >= limit);
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        total++; if (bus.frames_ok !== 16'd0 || bus.frames_dropped !== 16'd0) begin
            bad++; $display("FAIL reset_counters got ok=%0d drop=%0d exp 0/0", bus.frames_ok, bus.frames_dropped); end
        total++; if (bus.buf_level !== '0) begin bad++; $display("FAIL reset_buf_level got=%0d exp=0", bus.buf_level); end
    endtask

    task automatic test_resync();
        bit to;
        for (int i = 0; i < 20; i++) beat(8'(8'hA0 + i), 1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) beat(8'(8'hC0 + i), 1'(i == 29), 1'b0);
        idle_cycles(3);
        total++; if (bus.frames_dropped !== 16'd0) begin bad++; $display("FAIL resync_dropped got=%0d exp=0", bus.frames_dropped); end
        total++; if (bus.buf_level !== '0) begin bad++; $display("FAIL resync_level got=%0d exp=0", bus.buf_level); end
        send_frame(1, 64, 1'b0, 1'b1);
        exp_ok++;
        wait_drain(2000, to);
        total++; if (to) begin bad++; $display("FAIL resync_drain timeout got=%0d bytes exp=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL resync_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL resync_data at=%0d got=%h exp=%h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
        total++; if (bus.frames_ok !== 16'(exp_ok)) begin bad++; $display("FAIL resync_ok got=%0d exp=%0d", bus.frames_ok, exp_ok); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_single_64();
        bit to;
        send_frame(2, 64, 1'b0, 1'b1);
        exp_ok++;
        total++; if (bus.buf_level !== 12'd64) begin bad++; $display("FAIL single_level got=%0d exp=64", bus.buf_level); end
        idle_cycles(1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_latency_early got=%b exp=0", bus.out_valid); end
        idle_cycles(1);
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd14) begin
            bad++; $display("FAIL single_latency got valid=%b data=%h exp valid=1 data=0e", bus.out_valid, bus.out_data); end
        wait_drain(2000, to);
        total++; if (to) begin bad++; $display("FAIL single_drain timeout got=%0d bytes exp=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() !== 64) begin bad++; $display("FAIL single_len got=%0d exp=64", got_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL single_data at=%0d got=%h exp=%h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
        total++; if (bus.frames_ok !== 16'(exp_ok)) begin bad++; $display("FAIL single_ok got=%0d exp=%0d", bus.frames_ok, exp_ok); end
        total++; if (bus.buf_level !== '0) begin bad++; $display("FAIL single_level_end got=%0d exp=0", bus.buf_level); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_error_then_good();
        bit to;
        send_frame(3, 100, 1'b1, 1'b0);
        exp_drop++;
        idle_cycles(4);
        total++; if (bus.buf_level !== '0) begin bad++; $display("FAIL err_rollback_level got=%0d exp=0", bus.buf_level); end
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL err_leak got=%0d bytes exp=0", got_q.size()); end
        total++; if (bus.frames_dropped !== 16'(exp_drop)) begin bad++; $display("FAIL err_dropped got=%0d exp=%0d", bus.frames_dropped, exp_drop); end
        send_frame(4, 60, 1'b0, 1'b1);
        exp_ok++;
        wait_drain(2000, to);
        total++; if (to) begin bad++; $display("FAIL err_drain timeout got=%0d bytes exp=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() !== 60) begin bad++; $display("FAIL err_good_len got=%0d exp=60", got_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL err_good_data at=%0d got=%h exp=%h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
        total++; if (bus.frames_ok !== 16'(exp_ok)) begin bad++; $display("FAIL err_ok got=%0d exp=%0d", bus.frames_ok, exp_ok); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_runt();
        bit to;
        send_frame(5, 10, 1'b0, 1'b0);
        exp_drop++;
        idle_cycles(3);
        total++; if (bus.buf_level !== '0) begin bad++; $display("FAIL runt10_level got=%0d exp=0", bus.buf_level); end
        total++; if (bus.frames_dropped !== 16'(exp_drop)) begin bad++; $display("FAIL runt10_dropped got=%0d exp=%0d", bus.frames_dropped, exp_drop); end
        send_frame(6, 13, 1'b0, 1'b0);
        exp_drop++;
        send_frame(7, 14, 1'b0, 1'b1);
        exp_ok++;
        wait_drain(2000, to);
        total++; if (to) begin bad++; $display("FAIL runt_drain timeout got=%0d bytes exp=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() !== 14) begin bad++; $display("FAIL runt_min_len got=%0d exp=14", got_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL runt_min_data at=%0d got=%h exp=%h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
        total++; if (bus.frames_dropped !== 16'(exp_drop) || bus.frames_ok !== 16'(exp_ok)) begin
            bad++; $display("FAIL runt_counters got ok=%0d drop=%0d exp ok=%0d drop=%0d", bus.frames_ok, bus.frames_dropped, exp_ok, exp_drop); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        bit to;
        int ovf_cnt = 0;
        int ovf_at  = 0;
        logic [ADDR_W:0] lvl_full = '0;
        rdy_mode = 0;
        idle_cycles(2);
        for (int i = 0; i < 2100; i++) begin
            beat(8'(8 * 7 + i), 1'(i == 2099), 1'b0);
            if (bus.overflow) begin ovf_cnt++; ovf_at = i + 1; end
            if (i == 2047) lvl_full = bus.buf_level;
        end
        exp_drop++;
        idle_cycles(2);
        total++; if (lvl_full !== 12'd2048) begin bad++; $display("FAIL ovf_full_level got=%0d exp=2048", lvl_full); end
        total++; if (ovf_cnt !== 1) begin bad++; $display("FAIL ovf_pulse_count got=%0d exp=1", ovf_cnt); end
        total++; if (ovf_at !== 2049) begin bad++; $display("FAIL ovf_pulse_byte got=%0d exp=2049", ovf_at); end
        total++; if (bus.buf_level !== '0) begin bad++; $display("FAIL ovf_rollback_level got=%0d exp=0", bus.buf_level); end
        total++; if (bus.frames_dropped !== 16'(exp_drop)) begin bad++; $display("FAIL ovf_dropped got=%0d exp=%0d", bus.frames_dropped, exp_drop); end
        rdy_mode = 1;
        send_frame(9, 64, 1'b0, 1'b1);
        exp_ok++;
        wait_drain(2000, to);
        total++; if (to) begin bad++; $display("FAIL ovf_drain timeout got=%0d bytes exp=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() !== 64) begin bad++; $display("FAIL ovf_next_len got=%0d exp=64", got_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL ovf_next_data at=%0d got=%h exp=%h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit to;
        rdy_mode   = 2;
        stall_viol = 0;
        for (int k = 0; k < 20; k++) send_frame(10 + k, 100, 1'b0, 1'b1);
        exp_ok += 20;
        wait_drain(20000, to);
        total++; if (to) begin bad++; $display("FAIL b2b_drain timeout got=%0d bytes exp=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() !== 2000) begin bad++; $display("FAIL b2b_len got=%0d exp=2000", got_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL b2b_data at=%0d got=%h exp=%h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL b2b_stall_hold got=%0d changes exp=0", stall_viol); end
        total++; if (bus.frames_ok !== 16'(exp_ok) || bus.frames_dropped !== 16'(exp_drop)) begin
            bad++; $display("FAIL b2b_counters got ok=%0d drop=%0d exp ok=%0d drop=%0d", bus.frames_ok, bus.frames_dropped, exp_ok, exp_drop); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus.rx_mac_valid = 1'b0;
        bus.rx_mac_data  = 8'h00;
        bus.rx_mac_last  = 1'b0;
        bus.rx_mac_error = 1'b0;
        bus.out_ready    = 1'b0;
        test_reset();
        test_resync();
        test_single_64();
        test_error_then_good();
        test_runt();
        test_overflow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
Store-and-forward receive buffer directly downstream of the tri-speed MAC receive interface (rx_mac_valid/data/last/error). Accepts bytes on rx_mac_clk with no backpressure and writes them into a circular byte RAM. A frame is released to the downstream byte stream (valid/ready) only after its last byte arrives error-free. Errored, runt and overflowed frames are rolled back and counted, so no partial frame ever reaches the bridge logic.

Parameters:
ADDR_W, 11, log2 of buffer depth in bytes (2048).
MIN_LEN, 14, minimum accepted frame length in bytes; shorter frames are dropped.

Ports:
rx_mac_clk  in  1  sole clock; all logic rising-edge.
rstn  in  1  asynchronous active-low reset.
rx_mac_valid  in  1  input byte strobe from MAC.
rx_mac_data  in  8  input byte.
rx_mac_last  in  1  marks final byte of frame.
rx_mac_error  in  1  frame error; valid on any beat.
out_valid  out  1  output byte available.
out_data  out  8  output byte.
out_last  out  1  final byte of released frame.
out_ready  in  1  downstream accepts byte when high together with out_valid.
frames_ok  out  16  committed-frame count, saturating at 0xFFFF.
frames_dropped  out  16  dropped-frame count, saturating at 0xFFFF.
overflow  out  1  one-cycle pulse on first byte lost to a full buffer within a frame.
buf_level  out  ADDR_W+1  bytes stored, committed plus in-progress (wr_ptr - rd_ptr).

Behaviour:
- Reset: all pointers 0, counters 0, out_valid/out_last/overflow 0, out_data 0, state RESYNC.
- RAM: 2^ADDR_W entries x 9 bits ({last, data}); synchronous read, 1-cycle latency.
- Pointers are ADDR_W+1 bits (wrap bit): wr_ptr (working), cmt_ptr (committed), rd_ptr. Full when wr_ptr - rd_ptr == 2^ADDR_W.
- Write FSM states: RESYNC, IDLE, RECV, DROP.
  - RESYNC: discard beats; a beat with rx_mac_last -> IDLE. Prevents accepting the tail of a frame in progress at reset release.
  - IDLE/RECV: each beat, if not full, write at wr_ptr, wr_ptr++, len++ (16-bit saturating). Sticky bad flag set on rx_mac_error. First beat in IDLE -> RECV with len=1.
  - Beat while full -> DROP, pulse overflow, byte not written. A last beat arriving while full is handled as a drop.
  - In DROP, discard beats until last, then rollback.
  - Last beat, not full, bad=0, final len >= MIN_LEN: write with last bit set; cmt_ptr <= wr_ptr+1; frames_ok++ -> IDLE.
  - Otherwise (error, runt, DROP): wr_ptr <= cmt_ptr; frames_dropped++ -> IDLE.
  - len and bad clear on every transition to IDLE.
- Read side: a 2-entry output pipeline (RAM read register + output register, skid). Reads issue only while rd_ptr != cmt_ptr and a pipeline slot is free. Never reads uncommitted bytes.
  - Latency: commit in cycle N (last byte sampled at edge N) with buffer previously empty -> out_valid high in cycle N+2 with the first byte.
  - Throughput: 1 byte/cycle while out_ready is held high.
  - out_data/out_last are held stable while out_valid=1 and out_ready=0.
- rd_ptr advances on RAM read issue. buf_level uses rd_ptr, so up to 2 prefetched bytes are already counted as freed.
- Simultaneous commit and read, and rollback and read: independent. Rollback never moves wr_ptr below cmt_ptr.
- Back-to-back frames with no gap between last and the next first beat: fully supported.

Test Plan:
- Single 64-byte good frame, out_ready=1 -> out_valid rises 2 cycles after the last beat; 64 bytes in order, out_last on byte 64; frames_ok=1, buf_level returns to 0.
- 100-byte frame with rx_mac_error on final beat, then 60-byte good frame -> only the 60-byte frame appears; frames_dropped=1, frames_ok=1.
- 10-byte frame (runt, MIN_LEN=14) -> no output; frames_dropped=1; wr_ptr restored.
- out_ready=0, 2100-byte frame -> overflow pulses once at byte 2049; frame dropped, buf_level=0 after rollback. Then a 64-byte frame is accepted intact.
- Reset released mid-frame (30 beats remaining), followed by a 64-byte frame -> the 30-byte tail is discarded in RESYNC; only the 64-byte frame is output.
- 20 back-to-back 100-byte frames with random out_ready (50%) -> all 2000 bytes in order with correct out_last placement; data stable while stalled; frames_ok=20.
